// File: rtl/jtag_bsr_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bsr_pkg
// Description : Shared definitions for the boundary-scan register. Holds the
//               default pad counts, the pad-mux mode encoding and helpers that
//               give the chain slice bounds for a given pad configuration.
//               Chain layout, LSB first: IN[IN_LEN], OUT[N_GPIO], OE[N_GPIO].
// Revision    : 1.0 - initial release
// ============================================================================
package bsr_pkg;

    localparam int DEF_N_GPIO = 15;
    localparam int DEF_N_DIN  = 18;

    // Who drives the pads, as seen after the registered instruction decode.
    typedef enum logic [1:0] {
        MODE_FUNC   = 2'd0,
        MODE_EXTEST = 2'd1,
        MODE_INTEST = 2'd2
    } bsr_mode_e;

    function automatic int slice_in_hi(input int n_gpio, input int n_din);
        return n_gpio + n_din - 1;
    endfunction

    function automatic int slice_out_lo(input int n_gpio, input int n_din);
        return n_gpio + n_din;
    endfunction

    function automatic int slice_out_hi(input int n_gpio, input int n_din);
        return 2 * n_gpio + n_din - 1;
    endfunction

    function automatic int slice_oe_lo(input int n_gpio, input int n_din);
        return 2 * n_gpio + n_din;
    endfunction

    function automatic int slice_oe_hi(input int n_gpio, input int n_din);
        return 3 * n_gpio + n_din - 1;
    endfunction

    function automatic int chain_len(input int n_gpio, input int n_din);
        return 3 * n_gpio + n_din;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_bsr_ctrl_cell.sv
`default_nettype none
// ============================================================================
// Module      : bsr_cell
// Description : One boundary-scan cell: a capture/shift flop and, when
//               HAS_UPDATE is set, an update latch loaded from it.
// Ports       : tck_i, test_logic_reset_i (async, active-high),
//               capture_en/capture_d, shift_en/shift_d, update_en,
//               shift_q (chain bit), upd_q (update latch, 0 if absent).
//               Enables arrive already qualified and prioritised.
// Revision    : 1.0 - initial release
// ============================================================================
module bsr_cell #(
    parameter bit HAS_UPDATE = 1'b1
) (
    input  logic tck_i,
    input  logic test_logic_reset_i,
    input  logic capture_en,
    input  logic capture_d,
    input  logic shift_en,
    input  logic shift_d,
    input  logic update_en,
    output logic shift_q,
    output logic upd_q
);

    always_ff @(posedge tck_i or posedge test_logic_reset_i) begin
        if (test_logic_reset_i) begin
            shift_q <= 1'b0;
        end else if (capture_en) begin
            shift_q <= capture_d;
        end else if (shift_en) begin
            shift_q <= shift_d;
        end
    end

    generate
        if (HAS_UPDATE) begin : g_upd
            always_ff @(posedge tck_i or posedge test_logic_reset_i) begin
                if (test_logic_reset_i) begin
                    upd_q <= 1'b0;
                end else if (update_en) begin
                    upd_q <= shift_q;
                end
            end
        end else begin : g_no_upd
            logic unused_update_en;
            assign unused_update_en = update_en;
            assign upd_q            = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/jtag_bsr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : jtag_bsr_ctrl
// Description : Boundary-scan data register for SAMPLE/PRELOAD and EXTEST,
//               plus the pad output / output-enable mux between the core and
//               the update latches.
// Ports       : tck_i, test_logic_reset_i (async, active-high)
//               capture_dr_i, shift_dr_i, update_dr_i  - TAP DR strobes
//               extest_select_i, sample_preload_select_i - instruction decode
//               tdi_i / tdo_o                           - serial chain
//               pad_in_i [IN_LEN], core_out_i/core_oe_i [N_GPIO]
//               pad_out_o/pad_oe_o [N_GPIO], extest_active_o
// Option      : BSR_INTEST_EN adds intest_select_i, core_in_o and an update
//               stage on the IN cells.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_bsr_ctrl
    import bsr_pkg::*;
#(
    parameter int N_GPIO = DEF_N_GPIO,
    parameter int N_DIN  = DEF_N_DIN
) (
    input  logic                     tck_i,
    input  logic                     test_logic_reset_i,
    input  logic                     capture_dr_i,
    input  logic                     shift_dr_i,
    input  logic                     update_dr_i,
    input  logic                     extest_select_i,
    input  logic                     sample_preload_select_i,
    input  logic                     tdi_i,
    output logic                     tdo_o,
    input  logic [N_GPIO+N_DIN-1:0]  pad_in_i,
    input  logic [N_GPIO-1:0]        core_out_i,
    input  logic [N_GPIO-1:0]        core_oe_i,
`ifdef BSR_INTEST_EN
    input  logic                     intest_select_i,
    output logic [N_GPIO+N_DIN-1:0]  core_in_o,
`endif
    output logic [N_GPIO-1:0]        pad_out_o,
    output logic [N_GPIO-1:0]        pad_oe_o,
    output logic                     extest_active_o
);

    localparam int IN_LEN       = N_GPIO + N_DIN;
    localparam int L            = chain_len(N_GPIO, N_DIN);
    localparam int SLICE_IN_LO  = 0;
    localparam int SLICE_IN_HI  = slice_in_hi(N_GPIO, N_DIN);
    localparam int SLICE_OUT_LO = slice_out_lo(N_GPIO, N_DIN);
    localparam int SLICE_OUT_HI = slice_out_hi(N_GPIO, N_DIN);
    localparam int SLICE_OE_LO  = slice_oe_lo(N_GPIO, N_DIN);
    localparam int SLICE_OE_HI  = slice_oe_hi(N_GPIO, N_DIN);

    logic              sel;
    logic              capture_en;
    logic              shift_en;
    logic              update_en;
    logic              intest_active;
    logic [IN_LEN-1:0] in_capture;
    logic [L-1:0]      chain;
    logic [L-1:0]      shift_src;
    logic [L-1:0]      capture_vec;
    logic [L-1:0]      upd_vec;
    bsr_mode_e         mode;

`ifdef BSR_INTEST_EN
    localparam bit IN_HAS_UPD = 1'b1;
    logic [IN_LEN+2*N_GPIO-1:0] intest_cap_wide;
    logic                       unused_intest_cap_hi;

    assign sel = extest_select_i | sample_preload_select_i | intest_select_i;

    always_ff @(posedge tck_i or posedge test_logic_reset_i) begin
        if (test_logic_reset_i) begin
            intest_active <= 1'b0;
        end else begin
            intest_active <= intest_select_i;
        end
    end

    // Core outputs are zero-extended (or truncated) to the IN slice width.
    assign intest_cap_wide      = {{IN_LEN{1'b0}}, core_oe_i, core_out_i};
    assign unused_intest_cap_hi = ^intest_cap_wide[IN_LEN+2*N_GPIO-1:IN_LEN];
    assign in_capture = intest_active ? intest_cap_wide[IN_LEN-1:0] : pad_in_i;
    assign core_in_o  = intest_active ? upd_vec[SLICE_IN_HI:SLICE_IN_LO] : pad_in_i;
`else
    localparam bit IN_HAS_UPD = 1'b0;
    logic unused_upd_in;

    assign sel           = extest_select_i | sample_preload_select_i;
    assign intest_active = 1'b0;
    assign in_capture    = pad_in_i;
    assign unused_upd_in = ^upd_vec[SLICE_IN_HI:SLICE_IN_LO];
`endif

    // Overlapping strobes are illegal from the TAP; resolve them as
    // capture > shift > update so the result is still deterministic.
    assign capture_en = sel & capture_dr_i;
    assign shift_en   = sel & shift_dr_i & ~capture_dr_i;
    assign update_en  = sel & update_dr_i & ~capture_dr_i & ~shift_dr_i;

    assign shift_src   = {tdi_i, chain[L-1:1]};
    assign capture_vec = {pad_oe_o, pad_out_o, in_capture};
    assign tdo_o       = chain[0];

    generate
        for (genvar i = 0; i < L; i++) begin : g_chain
            bsr_cell #(
                .HAS_UPDATE((i >= SLICE_OUT_LO) ? 1'b1 : IN_HAS_UPD)
            ) u_cell (
                .tck_i              (tck_i),
                .test_logic_reset_i (test_logic_reset_i),
                .capture_en         (capture_en),
                .capture_d          (capture_vec[i]),
                .shift_en           (shift_en),
                .shift_d            (shift_src[i]),
                .update_en          (update_en),
                .shift_q            (chain[i]),
                .upd_q              (upd_vec[i])
            );
        end
    endgenerate

    // Registered select keeps the pads glitch-free while the IR changes.
    always_ff @(posedge tck_i or posedge test_logic_reset_i) begin
        if (test_logic_reset_i) begin
            extest_active_o <= 1'b0;
        end else begin
            extest_active_o <= extest_select_i;
        end
    end

    always_comb begin
        mode = MODE_FUNC;
        if (intest_active) begin
            mode = MODE_INTEST;
        end
        if (extest_active_o) begin
            mode = MODE_EXTEST;
        end
    end

    always_comb begin
        pad_out_o = core_out_i;
        pad_oe_o  = core_oe_i;
        case (mode)
            MODE_EXTEST: begin
                pad_out_o = upd_vec[SLICE_OUT_HI:SLICE_OUT_LO];
                pad_oe_o  = upd_vec[SLICE_OE_HI:SLICE_OE_LO];
            end
            MODE_INTEST: begin
                pad_oe_o  = '0;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/jtag_bsr_ctrl.md
Name: jtag_bsr_ctrl

Overview:
Parametrised boundary-scan data register for the test interface. It implements the capture, shift and update behaviour for the SAMPLE_PRELOAD and EXTEST instructions over a configurable number of bidirectional GPIO pads and input-only DIN pads. It sits between the TAP controller, which supplies the DR state strobes and instruction selects, and the pad ring. It muxes pad output and output-enable between the core and the update latch.

Parameters:
N_GPIO, 15, number of bidirectional pads; each has IN, OUT and OE cells.
N_DIN, 18, number of input-only pads; each has an IN cell only.
Derived: IN_LEN=N_GPIO+N_DIN, OUT_LEN=N_GPIO, OE_LEN=N_GPIO, L=IN_LEN+OUT_LEN+OE_LEN (63 by default).

Ports:
tck_i  in  1  test clock; all state changes on its rising edge
test_logic_reset_i  in  1  reset, asynchronous, active-high
capture_dr_i  in  1  TAP is in Capture-DR
shift_dr_i  in  1  TAP is in Shift-DR
update_dr_i  in  1  TAP is in Update-DR
extest_select_i  in  1  EXTEST instruction is loaded
sample_preload_select_i  in  1  SAMPLE/PRELOAD instruction is loaded
tdi_i  in  1  serial data in
tdo_o  out  1  serial data out, equal to shift[0]; negedge retiming is done in the TAP
pad_in_i  in  IN_LEN  pad input values: GPIO in [N_GPIO-1:0], DIN above them
core_out_i  in  N_GPIO  functional output data from the core
core_oe_i  in  N_GPIO  functional output enable from the core
pad_out_o  out  N_GPIO  output data to the pads
pad_oe_o  out  N_GPIO  output enable to the pads
extest_active_o  out  1  pads are currently driven from the update latch

Behaviour:
- Chain order, LSB first: IN[0..IN_LEN-1], then OUT, then OE. tdi_i enters at bit L-1. tdo_o is taken from bit 0.
- sel = extest_select_i | sample_preload_select_i. The block ignores all DR strobes when sel=0, and shift and update hold their values.
- Capture, on a rising tck edge with capture_dr_i and sel:
  - IN slice <- pad_in_i.
  - OUT slice <- pad_out_o.
  - OE slice <- pad_oe_o.
- Shift, on a rising edge with shift_dr_i and sel: shift <= {tdi_i, shift[L-1:1]}.
- Update, on a rising edge with update_dr_i and sel: the OUT and OE slices of shift are copied into upd_out and upd_oe. The IN slice has no update stage.
- If more than one strobe is asserted at once, priority is capture > shift > update. Such overlap is illegal from the TAP, but the block must still behave deterministically.
- extest_active_o is a flop that samples extest_select_i on every rising tck edge, giving one cycle of latency. This avoids pad glitches while the instruction changes.
- Pad mux:
  - extest_active_o=1: pad_out_o=upd_out and pad_oe_o=upd_oe.
  - Otherwise: pad_out_o=core_out_i and pad_oe_o=core_oe_i.
  - The mux is combinational after the flops.
- SAMPLE_PRELOAD never disturbs the pads. Values preloaded under it take effect on the pads the cycle after EXTEST is selected.
- If both selects are asserted, EXTEST semantics apply.
- Reset, asynchronous, including mid-shift:
  - shift=0, upd_out=0, upd_oe=0 (pads tri-state safe), extest_active_o=0.
  - The pads return to core control immediately, and tdo_o=0.
- Latency:
  - tdi to tdo is L shift cycles.
  - Update to pad is zero additional cycles when EXTEST is already active.

Optional Feature:
BSR_INTEST_EN:
- When defined, the block adds input port intest_select_i and output port core_in_o [IN_LEN-1:0], plus an upd_in latch. The upd_in latch is updated from the IN slice on update_dr_i when sel or intest_select_i is asserted.
- intest_select_i also counts toward sel for the capture, shift and update strobes.
- With intest active, again registered with one cycle of latency:
  - core_in_o = upd_in.
  - IN capture takes core_out_i/core_oe_i zero-extended, instead of pad_in_i.
  - Pads are forced to pad_oe_o=0.
- When intest is not active, core_in_o = pad_in_i.
- When the macro is undefined, neither port exists and the rest of the behaviour is as described above.

Decomposition:
- Package bsr_pkg holds the slice localparams (SLICE_IN_LO/HI, SLICE_OUT_LO/HI, SLICE_OE_LO/HI) as functions of N_GPIO/N_DIN, and a typedef for the mode encoding (MODE_FUNC, MODE_EXTEST, MODE_INTEST).
- One natural sub-module is bsr_cell, a single capture/shift/update cell. It is instantiated per bit with a parameter that selects whether an update stage is present.

Test Plan:
- Reset mid-shift: assert test_logic_reset_i after 20 shifts -> shift, update latches and extest_active_o are 0; pad_out_o/pad_oe_o follow core_*_i at once.
- SAMPLE capture: pad_in_i=33'h1_2345_6789, core_out_i=15'h5A5A, core_oe_i=15'h7FFF, then capture and 63 shifts -> the 63 tdo bits LSB-first equal {15'h7FFF,15'h5A5A,33'h1_2345_6789}; pads are unchanged throughout.
- PRELOAD then EXTEST: shift in OUT=15'h1234, OE=15'h00FF, then update, then select EXTEST -> pads stay at core values until 1 tck after select; then pad_out_o=15'h1234 and pad_oe_o=15'h00FF.
- EXTEST capture echo: with EXTEST active, capture -> the OUT/OE slices read back 15'h1234/15'h00FF; the IN slice equals pad_in_i.
- Strobes with no select: capture/shift/update with both selects 0 -> tdo_o, update latches and pads are unchanged.
- Strobe overlap: capture_dr_i and shift_dr_i asserted together -> the capture result is loaded and no shift occurs; N_GPIO=4, N_DIN=2 variant is rerun with L=14.
